// File: rtl/pattern_scan_pkg.sv
// pattern_scan_pkg: shared types and constants for the pattern scan scheduler.
//   state_t      : scheduler FSM states
//   DET_LAT      : detector latency, serial bit in -> pattern_detected out
//   DRAIN_CYCLES : extra enabled cycles after the last burst bit
//   FLUSH_CYCLES : minimum enable-low gap that clears the detector history
package pattern_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int DET_LAT      = 1;
    localparam int DRAIN_CYCLES = 1;
    localparam int FLUSH_CYCLES = 1;

endpackage

// File: rtl/pattern_scan_rr_arb.sv
// pattern_scan_rr_arb: combinational round-robin search.
//   req     : per-requester request levels
//   rr_ptr  : requester with highest priority this round (held by the parent)
//   gnt_vec : one-hot winner, all zero when no request
//   win_id  : encoded winner, 0 when no request
module pattern_scan_rr_arb #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] gnt_vec,
    output logic [ID_W-1:0]    win_id
);

    // Walk upward from rr_ptr with wrap; the first asserted request wins.
    always_comb begin
        logic found;
        int   idx;
        gnt_vec = '0;
        win_id  = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found        = 1'b1;
                win_id       = ID_W'(idx);
                gnt_vec[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pattern_scan_sched.sv
// pattern_scan_sched: round-robin sharing of one serial pattern detector.
// A granted requester's burst word is shifted LSB-first into the detector,
// detector hits are counted over the burst, and the count is reported with
// the requester ID.
//   clk, rstb              : clock, async active-low reset
//   req, burst_data        : requester levels and per-requester burst words
//   gnt                    : one-hot grant pulse (word captured this cycle)
//   busy                   : high from GRANT through DONE
//   det_serial_pattern,
//   det_enable             : drive the detector
//   det_pattern_detected   : detector hit, registered, one cycle latency
//   done, done_id,
//   hit_count              : burst result pulse; id/count held until next done
// Optional (macro PATTERN_SCAN_FIRST_HIT_EN):
//   first_hit_vld,
//   first_hit_idx          : burst bit index completing the first pattern
module pattern_scan_sched
    import pattern_scan_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int BURST_LEN = 16,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BURST_LEN-1:0] burst_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         busy,
    output logic                         det_serial_pattern,
    output logic                         det_enable,
    input  logic                         det_pattern_detected,
    output logic                         done,
    output logic [ID_W-1:0]              done_id,
`ifdef PATTERN_SCAN_FIRST_HIT_EN
    output logic [CNT_W-1:0]             hit_count,
    output logic                         first_hit_vld,
    output logic [CNT_W-1:0]             first_hit_idx
`else
    output logic [CNT_W-1:0]             hit_count
`endif
);

    state_t                             state;
    logic [ID_W-1:0]                    rr_ptr;
    logic [ID_W-1:0]                    cur_id;
    logic [BURST_LEN-1:0]               shreg;
    logic [CNT_W-1:0]                   bit_cnt;
    logic [CNT_W-1:0]                   hit_cnt;

    logic [NUM_REQ-1:0][BURST_LEN-1:0]  words;
    logic [BURST_LEN-1:0]               win_word;
    logic [NUM_REQ-1:0]                 arb_gnt;
    logic [ID_W-1:0]                    arb_id;
    logic [ID_W-1:0]                    ptr_nxt;
    logic                               req_any;
    logic                               start_grant;
    logic                               cnt_en;
    logic                               hit_inc;
    logic [CNT_W-1:0]                   cnt_idx;
    logic [CNT_W-1:0]                   hit_nxt;

    assign words    = burst_data;
    assign win_word = words[cur_id];
    assign req_any  = |req;

    pattern_scan_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .gnt_vec (arb_gnt),
        .win_id  (arb_id)
    );

    assign ptr_nxt     = (arb_id == ID_W'(NUM_REQ - 1)) ? '0 : arb_id + 1'b1;
    assign start_grant = ((state == ST_IDLE) || (state == ST_DONE)) && req_any;

    // Hits seen in SHIFT cycle k belong to burst bit k-DET_LAT; the hit for
    // the last bit arrives in DRAIN, which acts as counting index BURST_LEN.
    // SHIFT cycle 0 only sees the flushed detector and is never counted.
    always_comb begin
        cnt_en  = ((state == ST_SHIFT) && (bit_cnt >= CNT_W'(DET_LAT))) ||
                  (state == ST_DRAIN);
        cnt_idx = (state == ST_DRAIN) ? CNT_W'(BURST_LEN) : bit_cnt;
        hit_inc = cnt_en && det_pattern_detected;
        hit_nxt = hit_cnt;
        if (hit_inc && !(&hit_cnt))
            hit_nxt = hit_cnt + 1'b1;
    end

`ifdef PATTERN_SCAN_FIRST_HIT_EN
    logic             fh_vld;
    logic [CNT_W-1:0] fh_idx;
    logic             fh_vld_nxt;
    logic [CNT_W-1:0] fh_idx_nxt;

    always_comb begin
        fh_vld_nxt = fh_vld | hit_inc;
        fh_idx_nxt = fh_idx;
        if (hit_inc && !fh_vld)
            fh_idx_nxt = cnt_idx - CNT_W'(DET_LAT);
    end
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state              <= ST_IDLE;
            rr_ptr             <= '0;
            cur_id             <= '0;
            shreg              <= '0;
            bit_cnt            <= '0;
            hit_cnt            <= '0;
            gnt                <= '0;
            busy               <= 1'b0;
            det_serial_pattern <= 1'b0;
            det_enable         <= 1'b0;
            done               <= 1'b0;
            done_id            <= '0;
            hit_count          <= '0;
`ifdef PATTERN_SCAN_FIRST_HIT_EN
            fh_vld             <= 1'b0;
            fh_idx             <= '0;
            first_hit_vld      <= 1'b0;
            first_hit_idx      <= '0;
`endif
        end else begin
            gnt  <= '0;
            done <= 1'b0;

            // Arbitration happens on the edge into GRANT so gnt is a register.
            if (start_grant) begin
                state  <= ST_GRANT;
                gnt    <= arb_gnt;
                cur_id <= arb_id;
                rr_ptr <= ptr_nxt;
                busy   <= 1'b1;
            end

            case (state)
                ST_IDLE: ;
                ST_GRANT: begin
                    // Capture at the end of the gnt cycle; bit 0 goes out now.
                    det_enable         <= 1'b1;
                    det_serial_pattern <= win_word[0];
                    shreg              <= win_word >> 1;
                    bit_cnt            <= '0;
                    hit_cnt            <= '0;
`ifdef PATTERN_SCAN_FIRST_HIT_EN
                    fh_vld             <= 1'b0;
                    fh_idx             <= '0;
`endif
                    state              <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    hit_cnt <= hit_nxt;
`ifdef PATTERN_SCAN_FIRST_HIT_EN
                    fh_vld  <= fh_vld_nxt;
                    fh_idx  <= fh_idx_nxt;
`endif
                    if (bit_cnt == CNT_W'(BURST_LEN - 1)) begin
                        // DRAIN keeps enable high so the last bit's hit lands.
                        det_serial_pattern <= 1'b0;
                        state              <= ST_DRAIN;
                    end else begin
                        det_serial_pattern <= shreg[0];
                        shreg              <= shreg >> 1;
                        bit_cnt            <= bit_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    det_enable         <= 1'b0;
                    det_serial_pattern <= 1'b0;
                    done               <= 1'b1;
                    done_id            <= cur_id;
                    hit_count          <= hit_nxt;
`ifdef PATTERN_SCAN_FIRST_HIT_EN
                    first_hit_vld      <= fh_vld_nxt;
                    first_hit_idx      <= fh_vld_nxt ? fh_idx_nxt : '0;
`endif
                    state              <= ST_DONE;
                end
                ST_DONE: begin
                    if (!req_any) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_sched.sv
// Bench for pattern_scan_sched: behavioural 3'b101 detector, a burst-level
// reference model compared every cycle, plus directed literal checks.
module tb_pattern_scan_sched;

    localparam int NR  = 4;
    localparam int L   = 16;
    localparam int IDW = 2;
    localparam int CW  = 5;

    logic            clk = 1'b0;
    logic            rstb;
    logic [NR-1:0]   req;
    logic [NR*L-1:0] burst_data;
    logic [NR-1:0]   gnt;
    logic            busy;
    logic            det_serial_pattern;
    logic            det_enable;
    logic            det_pattern_detected;
    logic            done;
    logic [IDW-1:0]  done_id;
    logic [CW-1:0]   hit_count;
`ifdef PATTERN_SCAN_FIRST_HIT_EN
    logic            first_hit_vld;
    logic [CW-1:0]   first_hit_idx;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pattern_scan_sched #(.NUM_REQ(NR), .BURST_LEN(L)) dut (
        .clk                  (clk),
        .rstb                 (rstb),
        .req                  (req),
        .burst_data           (burst_data),
        .gnt                  (gnt),
        .busy                 (busy),
        .det_serial_pattern   (det_serial_pattern),
        .det_enable           (det_enable),
        .det_pattern_detected (det_pattern_detected),
        .done                 (done),
        .done_id              (done_id),
`ifdef PATTERN_SCAN_FIRST_HIT_EN
        .hit_count            (hit_count),
        .first_hit_vld        (first_hit_vld),
        .first_hit_idx        (first_hit_idx)
`else
        .hit_count            (hit_count)
`endif
    );

    // Detector: 3'b101 in arrival order, overlapping, registered output.
    logic [1:0] dhist = 2'b00;
    logic       pd_r  = 1'b0;
    always @(posedge clk or negedge rstb) begin
        if (!rstb || !det_enable) begin
            dhist <= 2'b00;
            pd_r  <= 1'b0;
        end else begin
            dhist <= {dhist[0], det_serial_pattern};
            pd_r  <= ({dhist, det_serial_pattern} == 3'b101);
        end
    end
    assign det_pattern_detected = pd_r & det_enable;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int i = 0; i < NR; i++)
            if (r[(p + i) % NR]) return (p + i) % NR;
        return 0;
    endfunction

    function automatic int hits_of(input logic [L-1:0] w);
        int n = 0;
        for (int i = 2; i < L; i++)
            if (w[i-2] && !w[i-1] && w[i]) n++;
        return n;
    endfunction

    function automatic int first_of(input logic [L-1:0] w);
        for (int i = 2; i < L; i++)
            if (w[i-2] && !w[i-1] && w[i]) return i;
        return -1;
    endfunction

    function automatic int id_of(input logic [NR-1:0] g);
        for (int i = 0; i < NR; i++)
            if (g[i]) return i;
        return -1;
    endfunction

    // ph: -1 idle, else cycles since the grant cycle (0 = gnt, L+2 = done)
    int          ph     = -1;
    int          m_win  = 0;
    int          m_ptr  = 0;
    logic [L-1:0] m_word = '0;
    int          e_id   = 0;
    int          e_hits = 0;
    int          e_fv   = 0;
    int          e_fi   = 0;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ph <= -1; m_ptr <= 0; m_win <= 0; m_word <= '0;
            e_id <= 0; e_hits <= 0; e_fv <= 0; e_fi <= 0;
        end else if (ph == -1 || ph == L + 2) begin
            if (req != '0) begin
                m_win <= pick(req, m_ptr);
                m_ptr <= (pick(req, m_ptr) + 1) % NR;
                ph    <= 0;
            end else begin
                ph <= -1;
            end
        end else if (ph == 0) begin
            m_word <= burst_data[m_win*L +: L];
            ph     <= 1;
        end else begin
            ph <= ph + 1;
            if (ph == L + 1) begin
                e_id   <= m_win;
                e_hits <= hits_of(m_word);
                e_fv   <= (first_of(m_word) >= 0) ? 1 : 0;
                e_fi   <= (first_of(m_word) >= 0) ? first_of(m_word) : 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("gnt",        gnt,       (ph == 0) ? (32'd1 << m_win) : 32'd0);
        chk("busy",       busy,      (ph >= 0) ? 32'd1 : 32'd0);
        chk("det_enable", det_enable, (ph >= 1 && ph <= L + 1) ? 32'd1 : 32'd0);
        chk("det_serial", det_serial_pattern,
            (ph >= 1 && ph <= L) ? 32'(m_word[ph-1]) : 32'd0);
        chk("done",       done,      (ph == L + 2) ? 32'd1 : 32'd0);
        chk("done_id",    done_id,   e_id);
        chk("hit_count",  hit_count, e_hits);
`ifdef PATTERN_SCAN_FIRST_HIT_EN
        chk("first_hit_vld", first_hit_vld, e_fv);
        chk("first_hit_idx", first_hit_idx, e_fi);
`endif
    end

    // ---------------- directed helpers ----------------
    task automatic wait_gnt(input int lim, output int c, output logic [NR-1:0] g);
        c = -1; g = '0;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (gnt != '0) begin c = cyc; g = gnt; return; end
        end
        total++; bad++;
        $display("FAIL gnt_timeout: got none want gnt within %0d cycles", lim);
    endtask

    task automatic wait_done(input int lim, output int c, output int id, output int h,
                             output int fv, output int fi);
        c = -1; id = -1; h = -1; fv = -1; fi = -1;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (done) begin
                c = cyc; id = int'(done_id); h = int'(hit_count);
`ifdef PATTERN_SCAN_FIRST_HIT_EN
                fv = int'(first_hit_vld); fi = int'(first_hit_idx);
`endif
                return;
            end
        end
        total++; bad++;
        $display("FAIL done_timeout: got none want done within %0d cycles", lim);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rstb = 1'b0; req = '0;
        @(posedge clk); #1 rstb = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int gc, dc, did, dh, fv, fi, rel, ndone, run;
        bit seen_en;
        logic [NR-1:0] gv;
        int gids[$];
        int gcyc[$];
        int gaps[$];
        int exp_ids[5] = '{0, 1, 2, 3, 0};

        rstb = 1'b0; req = '0; burst_data = '0;

        // Reset with random requests: everything held at zero.
        repeat (3) begin @(posedge clk); #1 req = NR'($urandom_range(0, 15)); end
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_en", det_enable, 0);
        chk("rst_done", done, 0);

        // Single requester, 16'h5555 -> 7 hits, first at bit 2.
        @(posedge clk); #1 req = 4'b0001; burst_data[15:0] = 16'h5555; rstb = 1'b1; rel = cyc;
        wait_gnt(5, gc, gv);
        chk("first_gnt_lat", gc - rel, 1);
        chk("gnt_req0", gv, 4'b0001);
        @(posedge clk); #1 req = '0;
        wait_done(30, dc, did, dh, fv, fi);
        chk("done_lat", dc - gc, 18);
        chk("done_id_0", did, 0);
        chk("hits_5555", dh, 7);
`ifdef PATTERN_SCAN_FIRST_HIT_EN
        chk("fh_vld_5555", fv, 1);
        chk("fh_idx_5555", fi, 2);
`endif
        @(negedge clk);
        chk("busy_fall", busy, 0);

        // Same requester, all-zero word -> no hits.
        @(posedge clk); #1 req = 4'b0001; burst_data[15:0] = 16'h0000;
        wait_gnt(5, gc, gv);
        @(posedge clk); #1 req = '0;
        wait_done(30, dc, did, dh, fv, fi);
        chk("hits_0000", dh, 0);
`ifdef PATTERN_SCAN_FIRST_HIT_EN
        chk("fh_vld_0000", fv, 0);
        chk("fh_idx_0000", fi, 0);
`endif

        // Round robin with all requests held.
        do_reset();
        @(posedge clk); #1 burst_data = {16'hFFFF, 16'hA5A5, 16'h0000, 16'h5555}; req = 4'b1111;
        run = 0; seen_en = 0;
        for (int k = 0; k < 120 && gids.size() < 5; k++) begin
            @(negedge clk);
            if (gnt != '0) begin gids.push_back(id_of(gnt)); gcyc.push_back(cyc); end
            if (det_enable) begin
                if (seen_en && run > 0) gaps.push_back(run);
                seen_en = 1; run = 0;
            end else begin
                run++;
            end
        end
        @(posedge clk); #1 req = '0;
        wait_done(30, dc, did, dh, fv, fi);
        chk("rr_count", gids.size(), 5);
        for (int k = 0; k < gids.size() && k < 5; k++) chk("rr_order", gids[k], exp_ids[k]);
        for (int k = 1; k < gcyc.size(); k++) chk("rr_spacing", gcyc[k] - gcyc[k-1], 19);
        chk("gap_count", gaps.size(), 3);
        foreach (gaps[k]) chk("en_gap", gaps[k], 2);

        // Reset in SHIFT cycle 5: enable drops at once, no done, pointer back to 0.
        @(posedge clk); #1 req = 4'b0001; burst_data = {16'hA000, 16'h0000, 16'h0005, 16'h5555};
        wait_gnt(5, gc, gv);
        @(posedge clk); #1 req = '0;
        repeat (5) @(posedge clk);
        #1 rstb = 1'b0; req = 4'b1010;
        #1 chk("async_en_drop", det_enable, 0);
        chk("async_busy_drop", busy, 0);
        ndone = 0;
        repeat (3) begin @(negedge clk); if (done) ndone++; end
        chk("no_done_after_rst", ndone, 0);
        @(posedge clk); #1 rstb = 1'b1; rel = cyc;
        wait_gnt(5, gc, gv);
        chk("post_rst_lat", gc - rel, 1);
        chk("post_rst_gnt", gv, 4'b0010);
        @(posedge clk); #1 req = 4'b1000;
        wait_done(30, dc, did, dh, fv, fi);
        chk("done_id_1", did, 1);
        chk("hits_0005", dh, 1);
        wait_gnt(5, gc, gv);
        chk("gnt_req3", gv, 4'b1000);
        @(posedge clk); #1 req = '0;
        wait_done(30, dc, did, dh, fv, fi);
        chk("done_id_3", did, 3);
        chk("hits_a000_last_bit", dh, 1);
`ifdef PATTERN_SCAN_FIRST_HIT_EN
        chk("fh_idx_a000", fi, 15);
`endif

        // Word changes the cycle after gnt: captured word is what counts.
        @(posedge clk); #1 req = 4'b0001; burst_data[15:0] = 16'h5555;
        wait_gnt(5, gc, gv);
        @(posedge clk); #1 burst_data[15:0] = 16'h0000; req = '0;
        wait_done(30, dc, did, dh, fv, fi);
        chk("hits_data_change", dh, 7);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
